demux_1_4_buf: RTL and testbench
================================

// Module: demux_1_4_buf
//
// PURPOSE
//   Buffered 1-to-4 demultiplexer: the distributing counterpart of the 4-to-1 datapath multiplexer.
//   - Routes one WIDTH-bit input word to one of four destination lanes, selected by sel.
//   - Each lane holds one registered entry with valid/ready flow control.
//   - Sits between a single result producer and up to four consumers (register file, bypass, memory, status).
//
// PARAMETERS
//   WIDTH    24   data width of input and of each lane
//   CNT_W    16   width of the accepted-transfer counter
//
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous reset, active high
//   enb        in   1        input enable; when low, no new word is accepted
//   a          in   WIDTH    input data word
//   sel        in   2        destination lane select, 0..3
//   a_valid    in   1        input word present
//   a_ready    out  1        input word accepted this cycle when a_valid is also high
//   y0..y3     out  WIDTH    lane data registers
//   y_valid    out  4        bit i: lane i holds a word
//   y_ready    in   4        bit i: consumer i takes lane i's word this cycle
//   xfer_cnt   out  CNT_W    count of accepted input words
//
// BEHAVIOUR
//   Reset:
//   - On rst high at a clk edge: y0..y3 = 0, y_valid = 0, xfer_cnt = 0.
//   - Buffered words are discarded; rst overrides every other input.
//   Lane free (combinational):
//   - free[i] = !y_valid[i] | y_ready[i].
//   - a_ready = enb & free[sel], combinational from enb, sel, y_valid and y_ready. No other combinational paths.
//   Accept:
//   - Accept = a_valid & a_ready.
//   - On the next edge: y[sel] <= a, y_valid[sel] <= 1, xfer_cnt <= xfer_cnt + 1.
//   - xfer_cnt wraps from 2^CNT_W-1 to 0 with no flag.
//   Drain:
//   - Lane i drains when y_valid[i] & y_ready[i].
//   - On the next edge y_valid[i] <= 0, unless the same lane is refilled that cycle.
//   Latency and data rules:
//   - Input to lane output latency is exactly 1 clk.
//   - Simultaneous drain and refill of one lane: new word is loaded, y_valid stays 1. Full rate: 1 word/clk per lane.
//   - Data on an invalid lane holds its last value; it is not cleared on drain.
//   - Unselected lanes are unaffected by an accept. Lanes drain independently of enb and sel.
//   Stall and select rules:
//   - Selected lane full and not draining: a_ready = 0; the producer holds a and sel stable until accepted.
//   - sel may change while a_valid is high and a_ready is low; a_ready follows the new sel in the same cycle.
//   - enb low: a_ready = 0 and xfer_cnt holds; lanes continue to drain.
//   State: per lane, EMPTY (y_valid=0) and FULL (y_valid=1).
//   - EMPTY -> FULL on accept.
//   - FULL -> EMPTY on drain without refill.
//   - FULL -> FULL on refill or on hold.
//
// CONFIGURATION
//   Macro DEMUX_BROADCAST_EN adds an input port bcast (1 bit).
//   With the macro defined and bcast = 1:
//   - sel is ignored; a_ready = enb & free[0] & free[1] & free[2] & free[3].
//   - Accept loads a into all four lanes and sets y_valid = 4'b1111.
//   - xfer_cnt increments by 1.
//   With the macro defined and bcast = 0: behaviour is identical to the macro-undefined build.
//   Without the macro: no bcast port; single-lane routing only.
//
// TESTING
//   1. rst=1 for 2 clk with a_valid=1 -> y_valid=0, y0..y3=0, xfer_cnt=0 throughout.
//   2. Accept one word per lane:
//      - a=010101 sel=0, a=020202 sel=1, a=030303 sel=2, a=040404 sel=3 on successive clk, y_ready=0.
//      - -> y0..y3 = 010101/020202/030303/040404, y_valid=1111, xfer_cnt=4.
//   3. Lane 2 full, y_ready=0, a=0A0A0A sel=2 -> a_ready=0, y2 stays 030303.
//      - Then y_ready[2]=1 -> a_ready=1 the same cycle; next clk y2=0A0A0A, y_valid[2]=1.
//   4. Streaming on lane 1 with y_ready[1]=1, a=1,2,3,4 on 4 consecutive clk.
//      - -> a_ready=1 every cycle; y1 shows 1,2,3,4 one clk later; xfer_cnt +4.
//   5. enb=0 with a_valid=1 -> a_ready=0, xfer_cnt unchanged.
//      - Lanes with y_ready=1 drain to y_valid=0.
//   6. Preload xfer_cnt to FFFF via accepts, accept one more -> xfer_cnt=0000.
//      - Then assert rst with lanes full -> y_valid=0 on the next clk.
//   Broadcast build (DEMUX_BROADCAST_EN):
//   - bcast=1, a=555555, all lanes empty -> y0..y3=555555, y_valid=1111, xfer_cnt +1.
//   - bcast=1 with lane 3 full and y_ready[3]=0 -> a_ready=0.

Source files
------------

// File: rtl/demux_1_4_buf.sv
// demux_1_4_buf: buffered 1-to-4 demultiplexer.
// One producer feeds four single-entry lanes. Each lane is a two-state
// EMPTY/FULL machine; y_valid is the direct view of that state.
// An accepted word lands in the selected lane one clock later, and a count
// of accepted words is kept.
// Optional feature: define DEMUX_BROADCAST_EN to add the bcast input. With
// bcast high, one word is written to all four lanes at once.
module demux_1_4_buf #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       sel,
  input  logic             a_valid,
  output logic             a_ready,
`ifdef DEMUX_BROADCAST_EN
  input  logic             bcast,
`endif
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready,
  output logic [CNT_W-1:0] xfer_cnt
);

  // Handshake: a word moves across an interface on a clock edge only when
  // valid and ready are both high in the cycle before that edge. On the input
  // side, a_ready depends on enb, sel, lane state and y_ready, but never on
  // a_valid. A lane's consumer may take the word while the same lane is being
  // refilled. This lets each lane move one word per clock.

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_t;

  lane_state_t      lane_state_q [4];
  lane_state_t      lane_state_d [4];
  logic [WIDTH-1:0] lane_data_q  [4];

  logic [3:0] lane_free;
  logic [3:0] lane_drain;
  logic [3:0] lane_load;
  logic       bcast_mode;
  logic       accept;

`ifdef DEMUX_BROADCAST_EN
  assign bcast_mode = bcast;
`else
  assign bcast_mode = 1'b0;
`endif

  // Per-lane status: a lane is free when it is empty or its word is leaving now.
  always_comb begin
    lane_free  = '0;
    lane_drain = '0;
    y_valid    = '0;
    for (int i = 0; i < 4; i++) begin
      y_valid[i]    = (lane_state_q[i] == LANE_FULL);
      lane_drain[i] = (lane_state_q[i] == LANE_FULL) & y_ready[i];
      lane_free[i]  = (lane_state_q[i] == LANE_EMPTY) | y_ready[i];
    end
  end

  // Input handshake and lane write enables. Broadcast needs every lane free.
  always_comb begin
    a_ready   = 1'b0;
    accept    = 1'b0;
    lane_load = '0;
    if (bcast_mode) begin
      a_ready = enb & (&lane_free);
    end else begin
      a_ready = enb & lane_free[sel];
    end
    accept = a_valid & a_ready;
    if (accept) begin
      if (bcast_mode) begin
        lane_load = 4'b1111;
      end else begin
        lane_load[sel] = 1'b1;
      end
    end
  end

  // Lane next state: a refill wins over a drain, so a lane stays FULL when
  // both happen in the same cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_state_d[i] = lane_state_q[i];
      if (lane_load[i]) begin
        lane_state_d[i] = LANE_FULL;
      end else if (lane_drain[i]) begin
        lane_state_d[i] = LANE_EMPTY;
      end
    end
  end

  // Lane state register; reset discards any buffered words.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        lane_state_q[i] <= LANE_EMPTY;
      end else begin
        lane_state_q[i] <= lane_state_d[i];
      end
    end
  end

  // Lane data registers. They load only when a word is written, and keep
  // their last value after the lane drains.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        lane_data_q[i] <= '0;
      end else if (lane_load[i]) begin
        lane_data_q[i] <= a;
      end
    end
  end

  // Accepted-word counter; a broadcast counts as one word and the count wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (accept) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

  assign y0 = lane_data_q[0];
  assign y1 = lane_data_q[1];
  assign y2 = lane_data_q[2];
  assign y3 = lane_data_q[3];

endmodule

// File: tb/tb_demux_1_4_buf.sv
// tb_demux_1_4_buf: scoreboard bench for demux_1_4_buf.
// Each lane is modelled as a queue that holds at most one word. The driver
// pushes a word into the queue on the edge that accepts it. The monitor
// checks the DUT against the queue heads and pops a word when the consumer
// takes it.
module tb_demux_1_4_buf;

  localparam int W  = 24;
  localparam int CW = 16;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          enb;
  logic [W-1:0]  a;
  logic [1:0]    sel;
  logic          a_valid;
  logic          bcast_v;
  logic [3:0]    y_ready;
  wire           a_ready;
  wire  [W-1:0]  y0, y1, y2, y3;
  wire  [3:0]    y_valid;
  wire  [CW-1:0] xfer_cnt;
  wire  [W-1:0]  ylane [4];

  assign ylane[0] = y0;
  assign ylane[1] = y1;
  assign ylane[2] = y2;
  assign ylane[3] = y3;

  demux_1_4_buf #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .a        (a),
    .sel      (sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
`ifdef DEMUX_BROADCAST_EN
    .bcast    (bcast_v),
`endif
    .y0       (y0),
    .y1       (y1),
    .y2       (y2),
    .y3       (y3),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .xfer_cnt (xfer_cnt)
  );

  // Reference model state
  logic [W-1:0]  exp_q [4][$];
  logic [W-1:0]  last_val [4];
  logic [CW-1:0] exp_cnt;
  logic          mon_en = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input int lane,
                       input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s lane %0d got %h expected %h", name, lane, got, exp);
    end
  endtask

  // Driver: applies one cycle of inputs, checks a_ready against the model and
  // updates the model on the clock edge.
  task automatic drive(input logic r, input logic e, input logic v,
                       input logic [W-1:0] d, input logic [1:0] s,
                       input logic [3:0] yr, input logic bc);
    logic [3:0] free;
    logic       exp_rdy;
    logic [3:0] pend_mask;
    rst = r; enb = e; a_valid = v; a = d; sel = s; y_ready = yr; bcast_v = bc;
    #2;
    for (int i = 0; i < 4; i++) free[i] = (exp_q[i].size() == 0) || yr[i];
    exp_rdy = e && (bc ? (&free) : free[s]);
    if (mon_en) check("a_ready", int'(s), {31'b0, a_ready}, {31'b0, exp_rdy});
    pend_mask = 4'b0000;
    if (!r && v && exp_rdy) pend_mask = bc ? 4'b1111 : (4'b0001 << s);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        exp_q[i].delete();
        last_val[i] = '0;
      end
      exp_cnt = '0;
    end else if (pend_mask != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        if (pend_mask[i]) begin
          exp_q[i].push_back(d);
          last_val[i] = d;
        end
      end
      exp_cnt = exp_cnt + 1'b1;
    end
    mon_en = 1'b1;
    #1;
  endtask

  // Monitor: compares the lanes and counter at each falling edge and pops
  // words that consumers take.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        check("y_valid", i, {31'b0, y_valid[i]}, {31'b0, exp_q[i].size() != 0});
        if (exp_q[i].size() != 0) begin
          check("lane_data", i, {8'b0, ylane[i]}, {8'b0, exp_q[i][0]});
          if (y_ready[i]) void'(exp_q[i].pop_front());
        end else begin
          check("held_data", i, {8'b0, ylane[i]}, {8'b0, last_val[i]});
        end
      end
      check("xfer_cnt", 0, {16'b0, xfer_cnt}, {16'b0, exp_cnt});
    end
  end

  // Stimulus
  initial begin
    int guard;
    logic [W-1:0] rv;
    rst = 1'b1; enb = 1'b0; a_valid = 1'b0; a = '0; sel = '0;
    y_ready = '0; bcast_v = 1'b0; exp_cnt = '0;
    for (int i = 0; i < 4; i++) last_val[i] = '0;
    @(posedge clk); #1;

    // Reset held for two clocks with a_valid high
    drive(1'b1, 1'b1, 1'b1, 24'hABCDEF, 2'd0, 4'b0000, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 24'h123456, 2'd1, 4'b0000, 1'b0);

    // One word into each lane
    drive(1'b0, 1'b1, 1'b1, 24'h010101, 2'd0, 4'b0000, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 24'h020202, 2'd1, 4'b0000, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 24'h030303, 2'd2, 4'b0000, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 24'h040404, 2'd3, 4'b0000, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 24'h000000, 2'd0, 4'b0000, 1'b0);
    check("four_lanes_cnt", 0, {16'b0, xfer_cnt}, 32'd4);

    // Stall on full lane 2, then release it with y_ready[2]
    drive(1'b0, 1'b1, 1'b1, 24'h0A0A0A, 2'd2, 4'b0000, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 24'h0A0A0A, 2'd2, 4'b0100, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 24'h000000, 2'd2, 4'b0000, 1'b0);

    // Full-rate streaming on lane 1
    for (int k = 1; k <= 4; k++)
      drive(1'b0, 1'b1, 1'b1, W'(k), 2'd1, 4'b0010, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 24'h000000, 2'd1, 4'b0010, 1'b0);

    // enb low: nothing is accepted, but the lanes still drain
    drive(1'b0, 1'b0, 1'b1, 24'h777777, 2'd0, 4'b1111, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 24'h777777, 2'd3, 4'b1111, 1'b0);

`ifdef DEMUX_BROADCAST_EN
    // Broadcast into empty lanes, then block it with lane 3 full
    drive(1'b0, 1'b1, 1'b1, 24'h555555, 2'd2, 4'b0000, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 24'h666666, 2'd0, 4'b0111, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 24'h000000, 2'd0, 4'b1111, 1'b0);
`endif

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      rv = W'($urandom);
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
            1'($urandom), rv, 2'($urandom), 4'($urandom),
`ifdef DEMUX_BROADCAST_EN
            ($urandom_range(0, 7) == 0)
`else
            1'b0
`endif
            );
    end

    // Count up to the wrap point on lane 0, then one more accept
    guard = 0;
    while (exp_cnt != 16'hFFFF && guard < 70000) begin
      drive(1'b0, 1'b1, 1'b1, W'($urandom), 2'd0, 4'b0001, 1'b0);
      guard++;
    end
    check("cnt_reached_ffff", 0, {16'b0, xfer_cnt}, 32'h0000FFFF);
    drive(1'b0, 1'b1, 1'b1, 24'h0BEEF0, 2'd0, 4'b0001, 1'b0);
    check("cnt_wrap", 0, {16'b0, xfer_cnt}, 32'h00000000);

    // Fill all lanes, then reset with lanes full
    for (int k = 0; k < 4; k++)
      drive(1'b0, 1'b1, 1'b1, W'($urandom), 2'(k), 4'b0000, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 24'h999999, 2'd0, 4'b0000, 1'b0);
    check("reset_clears_valid", 0, {28'b0, y_valid}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 24'h000000, 2'd0, 4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
